// File: rtl/micro_pc_sequencer.sv
// Microprogram sequencer: next control-store address generation with a hardware return stack.
// Optional loop counter (LDCNT/DJNZ on ops 6/7) is enabled by defining PCSEQ_LOOP_EN.
module micro_pc_sequencer #(
    parameter int               AW          = 11,
    parameter int               STACK_DEPTH = 4,
    parameter int               SPW         = 3,
    parameter logic [AW-1:0]    RESET_ADDR  = {AW{1'b0}},
    parameter int               CW          = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic [2:0]      op,
    input  logic            cond,
    input  logic [AW-1:0]   target,
    output logic [AW-1:0]   pc,
    output logic [SPW-1:0]  depth,
    output logic            overflow,
    output logic            underflow
);

    localparam logic [2:0] OP_INC    = 3'd0;
    localparam logic [2:0] OP_JMP    = 3'd1;
    localparam logic [2:0] OP_JMPC   = 3'd2;
    localparam logic [2:0] OP_CALL   = 3'd3;
    localparam logic [2:0] OP_RET    = 3'd4;
    localparam logic [2:0] OP_LDSKIP = 3'd5;
    localparam logic [2:0] OP_LDCNT  = 3'd6;
    localparam logic [2:0] OP_DJNZ   = 3'd7;

    localparam logic [AW-1:0]  PC_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [SPW-1:0] SP_ZERO = {SPW{1'b0}};
    localparam logic [SPW-1:0] SP_ONE  = {{(SPW-1){1'b0}}, 1'b1};
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

    if ((STACK_DEPTH < 1) || ((1 << SPW) <= STACK_DEPTH)) begin : g_bad_stack
        $error("micro_pc_sequencer: SPW too narrow for STACK_DEPTH");
    end
    if ((CW < 1) || (CW > AW)) begin : g_bad_cw
        $error("micro_pc_sequencer: CW must be in 1..AW");
    end

    logic [AW-1:0]  r_pc;
    logic [SPW-1:0] r_depth;
    logic           r_overflow;
    logic           r_underflow;
    logic [AW-1:0]  r_stack [0:STACK_DEPTH-1];

    logic [AW-1:0]  w_pc_inc;
    logic [AW-1:0]  w_pc_nxt;
    logic [AW-1:0]  w_top;
    logic [SPW-1:0] w_depth_nxt;
    logic           w_push;
    logic           w_ovf_set;
    logic           w_unf_set;

`ifdef PCSEQ_LOOP_EN
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_nxt;
`endif

    assign w_pc_inc = r_pc + PC_ONE;

    // Top-of-stack select: entry[depth-1], only meaningful when depth is non-zero.
    always_comb begin
        w_top = r_stack[0];
        for (int i = 0; i < STACK_DEPTH; i++) begin
            w_top = ((r_depth - SP_ONE) == SPW'(i)) ? r_stack[i] : w_top;
        end
    end

    // Next-state decode of the microinstruction operation.
    always_comb begin
        w_pc_nxt    = w_pc_inc;
        w_depth_nxt = r_depth;
        w_push      = 1'b0;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
`ifdef PCSEQ_LOOP_EN
        w_cnt_nxt   = r_cnt;
`endif
        case (op)
            OP_INC: begin
                w_pc_nxt = w_pc_inc;
            end
            OP_JMP: begin
                w_pc_nxt = target;
            end
            OP_JMPC: begin
                if (cond) begin
                    w_pc_nxt = target;
                end else begin
                    w_pc_nxt = w_pc_inc;
                end
            end
            OP_CALL: begin
                // The jump is taken even when the push is refused.
                w_pc_nxt = target;
                if (r_depth >= SP_FULL) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_push      = 1'b1;
                    w_depth_nxt = r_depth + SP_ONE;
                end
            end
            OP_RET: begin
                if (r_depth == SP_ZERO) begin
                    w_unf_set = 1'b1;
                    w_pc_nxt  = w_pc_inc;
                end else begin
                    w_pc_nxt    = w_top;
                    w_depth_nxt = r_depth - SP_ONE;
                end
            end
            OP_LDSKIP: begin
                w_pc_nxt = target + PC_ONE;
            end
`ifdef PCSEQ_LOOP_EN
            OP_LDCNT: begin
                w_cnt_nxt = target[CW-1:0];
                w_pc_nxt  = w_pc_inc;
            end
            OP_DJNZ: begin
                // Loading N yields exactly N taken branches before fall-through.
                if (r_cnt != CNT_ZERO) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                    w_pc_nxt  = target;
                end else begin
                    w_cnt_nxt = CNT_ZERO;
                    w_pc_nxt  = w_pc_inc;
                end
            end
`else
            OP_LDCNT: begin
                w_pc_nxt = w_pc_inc;
            end
            OP_DJNZ: begin
                w_pc_nxt = w_pc_inc;
            end
`endif
            default: begin
                w_pc_nxt = w_pc_inc;
            end
        endcase
    end

    // Architectural state: pc, depth and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_ADDR;
            r_depth     <= SP_ZERO;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (!hold) begin
            r_pc        <= w_pc_nxt;
            r_depth     <= w_depth_nxt;
            r_overflow  <= r_overflow | w_ovf_set;
            r_underflow <= r_underflow | w_unf_set;
        end
    end

    // Return-stack storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (!rst && !hold && w_push && (r_depth == SPW'(i))) begin
                r_stack[i] <= w_pc_inc;
            end
        end
    end

`ifdef PCSEQ_LOOP_EN
    // Loop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= CNT_ZERO;
        end else if (!hold) begin
            r_cnt <= w_cnt_nxt;
        end
    end
`endif

    assign pc        = r_pc;
    assign depth     = r_depth;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
